// File: rtl/tx_ant_switch.sv
// tx_ant_switch: transmit-side antenna selector.
// Each frame is sent on the antenna the receiver chose most recently, or on a
// forced antenna. The block sequences the T/R switch and the per-antenna PA
// enables, with programmable lead and tail guards around the sample burst, and
// routes {I,Q} samples to the DAC chain of the selected antenna.
module tx_ant_switch #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int GUARD_WIDTH   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       rx_ant_select,
    input  logic                       rx_ant_valid,
    input  logic                       force_ant_en,
    input  logic                       force_ant,
    input  logic [GUARD_WIDTH-1:0]     lead_cycles,
    input  logic [GUARD_WIDTH-1:0]     tail_cycles,
    input  logic                       tx_start,
    input  logic [2*IQ_DATA_WIDTH-1:0] tx_data_in,
    input  logic                       tx_data_in_strobe,
    input  logic                       tx_last,
    output logic                       tx_ready,
    output logic [2*IQ_DATA_WIDTH-1:0] data_ant1_out,
    output logic                       data_out_strobe_1,
    output logic [2*IQ_DATA_WIDTH-1:0] data_ant2_out,
    output logic                       data_out_strobe_2,
    output logic                       pa_en_1,
    output logic                       pa_en_2,
    output logic                       rf_sw_tx,
    output logic                       tx_ant,
    output logic                       tx_busy,
    output logic                       sample_dropped
);

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LEAD   = 2'd1,
        TX_ACTIVE = 2'd2,
        TX_TAIL   = 2'd3
    } tx_state_t;

    tx_state_t              state;
    tx_state_t              next_state;
    logic [GUARD_WIDTH-1:0] cnt;
    logic                   pref_ant;
    logic                   frame_start;
    logic                   accept;

    // A frame starts only from idle with the block enabled.
    assign frame_start = (state == TX_IDLE) && tx_start && enable;
    // A sample is taken whenever the ready window is open and a strobe arrives.
    assign accept      = tx_ready && tx_data_in_strobe;

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: guard counters pace LEAD/TAIL, enable low aborts any frame.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            TX_IDLE: begin
                if (frame_start) next_state = TX_LEAD;
            end
            TX_LEAD: begin
                if (!enable)                  next_state = TX_IDLE;
                else if (cnt == lead_cycles)  next_state = TX_ACTIVE;
            end
            TX_ACTIVE: begin
                if (!enable)                          next_state = TX_IDLE;
                else if (tx_data_in_strobe && tx_last) next_state = TX_TAIL;
            end
            TX_TAIL: begin
                if (!enable)                  next_state = TX_IDLE;
                else if (cnt == tail_cycles)  next_state = TX_IDLE;
            end
            default: next_state = TX_IDLE;
        endcase
    end

    // Guard counter: cleared on every state change, counts while in LEAD or TAIL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (state == TX_LEAD || state == TX_TAIL) begin
            cnt <= cnt + GUARD_WIDTH'(1);
        end
    end

    // Antenna tracking: preferred antenna follows every RX decision; the frame
    // antenna is latched once at frame start, with a same-cycle RX decision bypassing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pref_ant <= 1'b0;
            tx_ant   <= 1'b0;
        end else begin
            if (rx_ant_valid) pref_ant <= rx_ant_select;
            if (frame_start) begin
                tx_ant <= force_ant_en ? force_ant
                                       : (rx_ant_valid ? rx_ant_select : pref_ant);
            end
        end
    end

    // Sample routing: one-cycle registered path to the selected chain, zero elsewhere;
    // strobes outside the ready window are reported as dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_ant1_out     <= '0;
            data_ant2_out     <= '0;
            data_out_strobe_1 <= 1'b0;
            data_out_strobe_2 <= 1'b0;
            sample_dropped    <= 1'b0;
        end else begin
            data_out_strobe_1 <= accept && !tx_ant;
            data_out_strobe_2 <= accept && tx_ant;
            data_ant1_out     <= (accept && !tx_ant) ? tx_data_in : '0;
            data_ant2_out     <= (accept && tx_ant)  ? tx_data_in : '0;
            sample_dropped    <= tx_data_in_strobe && !tx_ready;
        end
    end

    // Output decode from the registered state: RF path is on for LEAD/ACTIVE/TAIL.
    always_comb begin
        tx_busy  = (state != TX_IDLE);
        tx_ready = (state == TX_ACTIVE);
        rf_sw_tx = tx_busy;
        pa_en_1  = tx_busy && !tx_ant;
        pa_en_2  = tx_busy && tx_ant;
    end

endmodule

// File: tb/tb_tx_ant_switch.sv
// tb_tx_ant_switch: directed scenario bench for tx_ant_switch.
module tb_tx_ant_switch;

    localparam int IQ = 16;
    localparam int GW = 8;
    localparam int DW = 2 * IQ;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          rx_ant_select;
    logic          rx_ant_valid;
    logic          force_ant_en;
    logic          force_ant;
    logic [GW-1:0] lead_cycles;
    logic [GW-1:0] tail_cycles;
    logic          tx_start;
    logic [DW-1:0] tx_data_in;
    logic          tx_data_in_strobe;
    logic          tx_last;
    logic          tx_ready;
    logic [DW-1:0] data_ant1_out;
    logic          data_out_strobe_1;
    logic [DW-1:0] data_ant2_out;
    logic          data_out_strobe_2;
    logic          pa_en_1;
    logic          pa_en_2;
    logic          rf_sw_tx;
    logic          tx_ant;
    logic          tx_busy;
    logic          sample_dropped;

    int checks = 0;
    int errors = 0;

    tx_ant_switch #(.IQ_DATA_WIDTH(IQ), .GUARD_WIDTH(GW)) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .rx_ant_select     (rx_ant_select),
        .rx_ant_valid      (rx_ant_valid),
        .force_ant_en      (force_ant_en),
        .force_ant         (force_ant),
        .lead_cycles       (lead_cycles),
        .tail_cycles       (tail_cycles),
        .tx_start          (tx_start),
        .tx_data_in        (tx_data_in),
        .tx_data_in_strobe (tx_data_in_strobe),
        .tx_last           (tx_last),
        .tx_ready          (tx_ready),
        .data_ant1_out     (data_ant1_out),
        .data_out_strobe_1 (data_out_strobe_1),
        .data_ant2_out     (data_ant2_out),
        .data_out_strobe_2 (data_out_strobe_2),
        .pa_en_1           (pa_en_1),
        .pa_en_2           (pa_en_2),
        .rf_sw_tx          (rf_sw_tx),
        .tx_ant            (tx_ant),
        .tx_busy           (tx_busy),
        .sample_dropped    (sample_dropped)
    );

    always #5 clock = ~clock;

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] sample(input int k);
        return 32'hA500_0000 + 32'(k * 17 + 1);
    endfunction

    // Pulse tx_start, then feed n samples whenever ready and record what the DUT does
    // over a fixed window. Observation index 0 is the first cycle after tx_start.
    task automatic run_frame(input int n, input logic exp_ant, input int inj_idx,
                             input logic inj_sel,
                             output int pa1, output int pa2, output int s1, output int s2,
                             output int rdy_first, output int busy_cyc,
                             output int last_out, output int bad);
        int sent = 0;
        int recv = 0;
        pa1 = 0; pa2 = 0; s1 = 0; s2 = 0; busy_cyc = 0; bad = 0;
        rdy_first = -1; last_out = -1;
        tx_start = 1'b1;
        step();
        tx_start     = 1'b0;
        rx_ant_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pa_en_1) pa1++;
            if (pa_en_2) pa2++;
            if (tx_busy) busy_cyc++;
            if (tx_ready && rdy_first < 0) rdy_first = i;
            if (data_out_strobe_1) begin s1++; last_out = i; end
            if (data_out_strobe_2) begin s2++; last_out = i; end
            if (!data_out_strobe_1 && data_ant1_out !== '0) bad++;
            if (!data_out_strobe_2 && data_ant2_out !== '0) bad++;
            if (exp_ant == 1'b0 && data_out_strobe_1) begin
                if (data_ant1_out !== sample(recv)) bad++;
                recv++;
            end
            if (exp_ant == 1'b1 && data_out_strobe_2) begin
                if (data_ant2_out !== sample(recv)) bad++;
                recv++;
            end
            rx_ant_valid = (i == inj_idx);
            if (i == inj_idx) rx_ant_select = inj_sel;
            if (tx_ready && sent < n) begin
                tx_data_in_strobe = 1'b1;
                tx_data_in        = sample(sent);
                tx_last           = (sent == n - 1);
                sent++;
            end else begin
                tx_data_in_strobe = 1'b0;
                tx_last           = 1'b0;
                tx_data_in        = '0;
            end
            step();
        end
        rx_ant_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
        checks++; if ({pa_en_1, pa_en_2, rf_sw_tx} !== 3'b000) begin errors++; $display("FAIL reset_rf got %b exp 000", {pa_en_1, pa_en_2, rf_sw_tx}); end
        checks++; if (tx_ant !== 1'b0) begin errors++; $display("FAIL reset_tx_ant got %b exp 0", tx_ant); end
        checks++; if ({tx_ready, data_out_strobe_1, data_out_strobe_2, sample_dropped} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {tx_ready, data_out_strobe_1, data_out_strobe_2, sample_dropped}); end
        checks++; if ({data_ant1_out, data_ant2_out} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {data_ant1_out, data_ant2_out}); end
        reset = 1'b0;
        step();
    endtask

    // RX-preferred antenna 2, lead 3, tail 2, ten samples.
    task automatic test_pref_ant();
        int pa1, pa2, s1, s2, rdy, busy, lo, bad;
        lead_cycles = 8'd3; tail_cycles = 8'd2;
        rx_ant_valid = 1'b1; rx_ant_select = 1'b1;
        step();
        rx_ant_valid = 1'b0;
        run_frame(10, 1'b1, -1, 1'b0, pa1, pa2, s1, s2, rdy, busy, lo, bad);
        checks++; if (pa2 !== 17) begin errors++; $display("FAIL pref_pa2_cycles got %0d exp 17", pa2); end
        checks++; if (pa1 !== 0) begin errors++; $display("FAIL pref_pa1_cycles got %0d exp 0", pa1); end
        checks++; if (s2 !== 10 || s1 !== 0) begin errors++; $display("FAIL pref_strobes got s1=%0d s2=%0d exp s1=0 s2=10", s1, s2); end
        checks++; if (rdy !== 4) begin errors++; $display("FAIL pref_ready_first got %0d exp 4", rdy); end
        checks++; if (busy !== 17) begin errors++; $display("FAIL pref_busy_cycles got %0d exp 17", busy); end
        checks++; if (lo !== 14) begin errors++; $display("FAIL pref_last_out got %0d exp 14", lo); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pref_data got %0d bad exp 0", bad); end
        checks++; if (tx_ant !== 1'b1) begin errors++; $display("FAIL pref_tx_ant got %b exp 1", tx_ant); end
    endtask

    // Forced antenna 1 overrides a preferred antenna 2.
    task automatic test_force();
        int pa1, pa2, s1, s2, rdy, busy, lo, bad;
        lead_cycles = 8'd1; tail_cycles = 8'd1;
        force_ant_en = 1'b1; force_ant = 1'b0;
        run_frame(4, 1'b0, -1, 1'b0, pa1, pa2, s1, s2, rdy, busy, lo, bad);
        force_ant_en = 1'b0;
        checks++; if (tx_ant !== 1'b0) begin errors++; $display("FAIL force_tx_ant got %b exp 0", tx_ant); end
        checks++; if (pa2 !== 0 || pa1 !== 8) begin errors++; $display("FAIL force_pa got pa1=%0d pa2=%0d exp pa1=8 pa2=0", pa1, pa2); end
        checks++; if (s1 !== 4 || s2 !== 0) begin errors++; $display("FAIL force_strobes got s1=%0d s2=%0d exp s1=4 s2=0", s1, s2); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL force_data got %0d bad exp 0", bad); end
    endtask

    // Same-cycle RX decision bypasses; a mid-frame one only affects the next frame.
    task automatic test_bypass();
        int pa1, pa2, s1, s2, rdy, busy, lo, bad;
        lead_cycles = 8'd1; tail_cycles = 8'd1;
        rx_ant_valid = 1'b1; rx_ant_select = 1'b0;
        step();
        rx_ant_select = 1'b1;
        run_frame(4, 1'b1, 3, 1'b0, pa1, pa2, s1, s2, rdy, busy, lo, bad);
        checks++; if (tx_ant !== 1'b1) begin errors++; $display("FAIL bypass_tx_ant got %b exp 1", tx_ant); end
        checks++; if (s2 !== 4 || pa1 !== 0) begin errors++; $display("FAIL bypass_route got s2=%0d pa1=%0d exp s2=4 pa1=0", s2, pa1); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bypass_data got %0d bad exp 0", bad); end
        run_frame(2, 1'b0, -1, 1'b0, pa1, pa2, s1, s2, rdy, busy, lo, bad);
        checks++; if (tx_ant !== 1'b0) begin errors++; $display("FAIL bypass_next_tx_ant got %b exp 0", tx_ant); end
        checks++; if (s1 !== 2 || s2 !== 0) begin errors++; $display("FAIL bypass_next_route got s1=%0d s2=%0d exp s1=2 s2=0", s1, s2); end
    endtask

    // Zero-length guards.
    task automatic test_min_guard();
        int pa1, pa2, s1, s2, rdy, busy, lo, bad;
        lead_cycles = 8'd0; tail_cycles = 8'd0;
        run_frame(3, 1'b0, -1, 1'b0, pa1, pa2, s1, s2, rdy, busy, lo, bad);
        checks++; if (rdy !== 1) begin errors++; $display("FAIL minguard_ready_first got %0d exp 1", rdy); end
        checks++; if (busy !== 5) begin errors++; $display("FAIL minguard_busy got %0d exp 5", busy); end
        checks++; if (lo !== 4) begin errors++; $display("FAIL minguard_last_out got %0d exp 4", lo); end
        checks++; if (s1 !== 3 || pa1 !== 5) begin errors++; $display("FAIL minguard_s1_pa1 got s1=%0d pa1=%0d exp 3 5", s1, pa1); end
    endtask

    // Strobes in LEAD and TAIL are dropped and reported.
    task automatic test_dropped();
        lead_cycles = 8'd2; tail_cycles = 8'd2;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        tx_data_in_strobe = 1'b1; tx_data_in = 32'hDEAD_0001;
        step();
        checks++; if (sample_dropped !== 1'b1) begin errors++; $display("FAIL drop_lead_pulse got %b exp 1", sample_dropped); end
        checks++; if ({data_out_strobe_1, data_out_strobe_2} !== 2'b00) begin errors++; $display("FAIL drop_lead_out got %b exp 00", {data_out_strobe_1, data_out_strobe_2}); end
        tx_data_in_strobe = 1'b0;
        step();
        checks++; if (sample_dropped !== 1'b0) begin errors++; $display("FAIL drop_lead_clear got %b exp 0", sample_dropped); end
        step();
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL drop_active_ready got %b exp 1", tx_ready); end
        tx_data_in_strobe = 1'b1; tx_last = 1'b1; tx_data_in = 32'h0BAD_F00D;
        step();
        checks++; if (data_out_strobe_1 !== 1'b1 || data_ant1_out !== 32'h0BAD_F00D) begin errors++; $display("FAIL drop_active_out got %b %h exp 1 0badf00d", data_out_strobe_1, data_ant1_out); end
        tx_last = 1'b0; tx_data_in = 32'hDEAD_0002;
        step();
        checks++; if (sample_dropped !== 1'b1 || data_out_strobe_1 !== 1'b0) begin errors++; $display("FAIL drop_tail1 got drop=%b s1=%b exp 1 0", sample_dropped, data_out_strobe_1); end
        step();
        checks++; if (sample_dropped !== 1'b1 || data_out_strobe_1 !== 1'b0) begin errors++; $display("FAIL drop_tail2 got drop=%b s1=%b exp 1 0", sample_dropped, data_out_strobe_1); end
        tx_data_in_strobe = 1'b0; tx_data_in = '0;
        step();
        checks++; if (sample_dropped !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL drop_end got drop=%b busy=%b exp 0 0", sample_dropped, tx_busy); end
    endtask

    // enable low mid-ACTIVE, then asynchronous reset mid-LEAD.
    task automatic test_abort();
        int pa1, pa2, s1, s2, rdy, busy, lo, bad;
        lead_cycles = 8'd0; tail_cycles = 8'd5;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        tx_data_in_strobe = 1'b1; tx_data_in = 32'h1234_5678;
        step();
        checks++; if (data_out_strobe_1 !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL abort_pre got s1=%b ready=%b exp 1 1", data_out_strobe_1, tx_ready); end
        tx_data_in_strobe = 1'b0; enable = 1'b0;
        step();
        checks++; if ({tx_busy, pa_en_1, pa_en_2, rf_sw_tx} !== 4'b0000) begin errors++; $display("FAIL abort_rf got %b exp 0000", {tx_busy, pa_en_1, pa_en_2, rf_sw_tx}); end
        checks++; if ({data_out_strobe_1, data_out_strobe_2, tx_ready} !== 3'b000) begin errors++; $display("FAIL abort_strobes got %b exp 000", {data_out_strobe_1, data_out_strobe_2, tx_ready}); end
        enable = 1'b1;
        lead_cycles = 8'd5;
        rx_ant_valid = 1'b1; rx_ant_select = 1'b1;
        step();
        rx_ant_valid = 1'b0;
        force_ant_en = 1'b1; force_ant = 1'b1;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0; force_ant_en = 1'b0; force_ant = 1'b0;
        step();
        checks++; if (pa_en_2 !== 1'b1 || tx_ant !== 1'b1) begin errors++; $display("FAIL rst_pre got pa2=%b ant=%b exp 1 1", pa_en_2, tx_ant); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({tx_busy, pa_en_1, pa_en_2, rf_sw_tx, tx_ant} !== 5'b00000) begin errors++; $display("FAIL rst_async got %b exp 00000", {tx_busy, pa_en_1, pa_en_2, rf_sw_tx, tx_ant}); end
        step();
        reset = 1'b0;
        lead_cycles = 8'd0; tail_cycles = 8'd0;
        run_frame(1, 1'b0, -1, 1'b0, pa1, pa2, s1, s2, rdy, busy, lo, bad);
        checks++; if (tx_ant !== 1'b0 || s1 !== 1 || s2 !== 0) begin errors++; $display("FAIL rst_pref_cleared got ant=%b s1=%0d s2=%0d exp 0 1 0", tx_ant, s1, s2); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        rx_ant_select = 1'b0; rx_ant_valid = 1'b0;
        force_ant_en = 1'b0; force_ant = 1'b0;
        lead_cycles = '0; tail_cycles = '0;
        tx_start = 1'b0; tx_data_in = '0; tx_data_in_strobe = 1'b0; tx_last = 1'b0;
        #1;
        test_reset();
        test_pref_ant();
        test_force();
        test_bypass();
        test_min_guard();
        test_dropped();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
